// File: rtl/mem_stage_responder_if.sv
// rtl/mem_stage_responder_if.sv - MEM-stage request/response bus between pipeline and data-memory responder
interface mem_stage_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [1:0]  Size;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Stall;
  logic        Misalign;

  // pipeline side: issues requests, observes completion and stall
  modport master (
    output MemRead, MemWrite, Address, WriteData, Size,
    input  ReadData, Ready, Stall, Misalign
  );

  // memory side
  modport slave (
    input  MemRead, MemWrite, Address, WriteData, Size,
    output ReadData, Ready, Stall, Misalign
  );
endinterface

// File: rtl/mem_stage_responder.sv
// rtl/mem_stage_responder.sv - multi-cycle MEM-stage data memory (optional macro MEM_MISALIGN_CHK_EN)
module mem_stage_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  mem_stage_responder_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic [31:0]       mem_q [DEPTH];

  logic              request;
  logic              live;
  logic              finish;
  logic [ADDR_W+1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [1:0]        op_size;
  logic              op_wr;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rword;
  logic              mis;
  logic [3:0]        be_d;
  logic [31:0]       wlane_d;
  logic [31:0]       load_d;
  logic              unused_addr_hi;

  assign request = bus.MemRead | bus.MemWrite;

  // In IDLE the access may finish on the accepting edge (zero wait states),
  // so the live inputs are used there; afterwards the captured copy is used.
  assign live     = (state_q == ST_IDLE);
  assign op_addr  = live ? bus.Address[ADDR_W+1:0] : addr_q;
  assign op_wdata = live ? bus.WriteData : wdata_q;
  assign op_size  = live ? bus.Size : size_q;
  assign op_wr    = live ? bus.MemWrite : wr_q;
  assign idx      = op_addr[ADDR_W+1:2];
  assign rword    = mem_q[idx];

  assign unused_addr_hi = ^bus.Address[31:ADDR_W+2];

  // edge that enters RESP: commit point for stores and load data
  assign finish = (live && request && (WAIT_CYCLES == 0)) ||
                  ((state_q == ST_WAIT) && (cnt_q == 4'd0));

`ifdef MEM_MISALIGN_CHK_EN
  assign mis = ((op_size == 2'b01) && op_addr[0]) ||
               (((op_size == 2'b00) || (op_size == 2'b11)) && (op_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // lane enables, replicated store data and right-justified load data
  always_comb begin
    be_d    = 4'b0000;
    wlane_d = op_wdata;
    load_d  = rword;
    case (op_size)
      2'b01: begin
        be_d    = op_addr[1] ? 4'b1100 : 4'b0011;
        wlane_d = {op_wdata[15:0], op_wdata[15:0]};
        load_d  = op_addr[1] ? {16'h0000, rword[31:16]} : {16'h0000, rword[15:0]};
      end
      2'b10: begin
        be_d    = 4'b0001 << op_addr[1:0];
        wlane_d = {4{op_wdata[7:0]}};
        load_d  = {24'h000000, rword[8*op_addr[1:0] +: 8]};
      end
      default: begin
        be_d    = 4'b1111;
        wlane_d = op_wdata;
        load_d  = rword;
      end
    endcase
    if (mis) begin
      be_d   = 4'b0000;
      load_d = 32'h0000_0000;
    end
  end

  // array write: only selected lanes, never while reset is asserted
  always_ff @(posedge Clk) begin
    if (Reset && finish && op_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) mem_q[idx][8*i +: 8] <= wlane_d[8*i +: 8];
      end
    end
  end

  // request FSM with registered Ready and load data
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= finish;
      if (finish && !op_wr) rdata_q <= load_d;
      case (state_q)
        ST_IDLE: begin
          if (request) begin
            addr_q  <= bus.Address[ADDR_W+1:0];
            wdata_q <= bus.WriteData;
            size_q  <= bus.Size;
            wr_q    <= bus.MemWrite;
            cnt_q   <= CNT_INIT;
            state_q <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  logic misalign_q;

  // sticky misaligned-access flag
  always_ff @(posedge Clk) begin
    if (!Reset)             misalign_q <= 1'b0;
    else if (finish && mis) misalign_q <= 1'b1;
  end

  assign bus.Misalign = misalign_q;
`else
  assign bus.Misalign = 1'b0;
`endif

  assign bus.ReadData = rdata_q;
  assign bus.Ready    = ready_q;
  assign bus.Stall    = (live && request) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_stage_responder.sv
// tb/tb_mem_stage_responder.sv - table-driven scoreboard bench for mem_stage_responder
module tb_mem_stage_responder;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  vec_t vq[$];
  logic [31:0] exp_q[$];

  mem_stage_responder_if bus2();
  mem_stage_responder_if bus0();

  mem_stage_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
    .Clk(clk), .Reset(rstn), .bus(bus2.slave)
  );
  mem_stage_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .Clk(clk), .Reset(rstn), .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, input logic [31:0] e);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.sz = sz; v.exp = e;
    return v;
  endfunction

  task automatic idle_inputs();
    bus2.MemRead = 1'b0; bus2.MemWrite = 1'b0;
    bus0.MemRead = 1'b0; bus0.MemWrite = 1'b0;
  endtask

  // one access on the WAIT_CYCLES=2 instance; latency, stall and data checked
  task automatic access(input vec_t v);
    int cyc;
    bit got;
    logic [31:0] e;
    @(negedge clk);
    bus2.MemRead = v.rd; bus2.MemWrite = v.wr;
    bus2.Address = v.addr; bus2.WriteData = v.wd; bus2.Size = v.sz;
    exp_q.push_back(v.exp);
    #1;
    chk({v.name, ".stall_T"}, 32'(bus2.Stall), 32'd1);
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      bus2.MemRead = 1'b0; bus2.MemWrite = 1'b0;
      #1;
      if (bus2.Ready) got = 1;
      else if (cyc <= 2) chk({v.name, ".stall_wait"}, 32'(bus2.Stall), 32'd1);
    end
    chk({v.name, ".latency"}, 32'(cyc), 32'd3);
    if (got) begin
      e = exp_q.pop_front();
      chk({v.name, ".stall_resp"}, 32'(bus2.Stall), 32'd0);
      chk({v.name, ".rdata"}, bus2.ReadData, e);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    idle_inputs();
    bus2.Address = 32'h0; bus2.WriteData = 32'h0; bus2.Size = 2'b00;
    bus0.Address = 32'h0; bus0.WriteData = 32'h0; bus0.Size = 2'b00;

    // reset with a request held high
    @(negedge clk);
    rstn = 1'b0;
    bus2.MemRead = 1'b1; bus2.MemWrite = 1'b1; bus2.Address = 32'h10; bus2.WriteData = 32'h99;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle_inputs();
    #1;
    chk("rst.rdata", bus2.ReadData, 32'h0);
    chk("rst.ready", 32'(bus2.Ready), 32'd0);
    chk("rst.stall", 32'(bus2.Stall), 32'd0);
    chk("rst.misalign", 32'(bus2.Misalign), 32'd0);
    chk("rst0.ready", 32'(bus0.Ready), 32'd0);

    vq.push_back(mk("sw10",     0, 1, 32'h10,   32'hDEADBEEF, 2'b00, 32'h0));
    vq.push_back(mk("lw10",     1, 0, 32'h10,   32'h0,        2'b00, 32'hDEADBEEF));
    vq.push_back(mk("sw10b",    0, 1, 32'h10,   32'h11223344, 2'b00, 32'hDEADBEEF));
    vq.push_back(mk("sb13",     0, 1, 32'h13,   32'hFFFFFFA5, 2'b10, 32'hDEADBEEF));
    vq.push_back(mk("lw10c",    1, 0, 32'h10,   32'h0,        2'b00, 32'hA5223344));
    vq.push_back(mk("lb13",     1, 0, 32'h13,   32'h0,        2'b10, 32'h000000A5));
    vq.push_back(mk("lb11",     1, 0, 32'h11,   32'h0,        2'b10, 32'h00000033));
    vq.push_back(mk("sw20",     0, 1, 32'h20,   32'h0,        2'b00, 32'h00000033));
    vq.push_back(mk("sh22",     0, 1, 32'h22,   32'h12348001, 2'b01, 32'h00000033));
    vq.push_back(mk("lw20",     1, 0, 32'h20,   32'h0,        2'b00, 32'h80010000));
    vq.push_back(mk("lh22",     1, 0, 32'h22,   32'h0,        2'b01, 32'h00008001));
    vq.push_back(mk("lh20",     1, 0, 32'h20,   32'h0,        2'b01, 32'h00000000));
    vq.push_back(mk("both40",   1, 1, 32'h40,   32'hCAFEF00D, 2'b00, 32'h00000000));
    vq.push_back(mk("lw1010",   1, 0, 32'h1010, 32'h0,        2'b00, 32'hA5223344));
    vq.push_back(mk("lw40sz3",  1, 0, 32'h40,   32'h0,        2'b11, 32'hCAFEF00D));
    vq.push_back(mk("sb41",     0, 1, 32'h41,   32'h00000077, 2'b10, 32'hCAFEF00D));
    vq.push_back(mk("lw40",     1, 0, 32'h40,   32'h0,        2'b00, 32'hCAFE770D));
    vq.push_back(mk("sh21",     0, 1, 32'h21,   32'h0000BEEF, 2'b01, 32'hCAFE770D));
`ifdef MEM_MISALIGN_CHK_EN
    vq.push_back(mk("lh21",     1, 0, 32'h21,   32'h0,        2'b01, 32'h00000000));
    vq.push_back(mk("lw20m",    1, 0, 32'h20,   32'h0,        2'b00, 32'h80010000));
`else
    vq.push_back(mk("lh21",     1, 0, 32'h21,   32'h0,        2'b01, 32'h0000BEEF));
    vq.push_back(mk("lw20m",    1, 0, 32'h20,   32'h0,        2'b00, 32'h8001BEEF));
`endif

    for (int i = 0; i < vq.size(); i++) access(vq[i]);

`ifdef MEM_MISALIGN_CHK_EN
    chk("misalign.sticky", 32'(bus2.Misalign), 32'd1);
`else
    chk("misalign.tied", 32'(bus2.Misalign), 32'd0);
`endif

    // reset with a store request held high must not commit it
    @(negedge clk);
    rstn = 1'b0;
    bus2.MemWrite = 1'b1; bus2.Address = 32'h10; bus2.WriteData = 32'h0; bus2.Size = 2'b00;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle_inputs();
    #1;
    chk("rst2.rdata", bus2.ReadData, 32'h0);
    chk("rst2.misalign", 32'(bus2.Misalign), 32'd0);
    chk("rst2.stall", 32'(bus2.Stall), 32'd0);
    access(mk("lw10_after_rst", 1, 0, 32'h10, 32'h0, 2'b00, 32'hA5223344));

    // reset landing in WAIT aborts the store
    @(negedge clk);
    bus2.MemWrite = 1'b1; bus2.Address = 32'h40; bus2.WriteData = 32'h11111111; bus2.Size = 2'b00;
    @(negedge clk);
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("abort.ready", 32'(bus2.Ready), 32'd0);
      chk("abort.stall", 32'(bus2.Stall), 32'd0);
      @(negedge clk);
    end
    access(mk("lw40_after_abort", 1, 0, 32'h40, 32'h0, 2'b00, 32'hCAFE770D));

    // zero wait states: back-to-back stores, aliasing above DEPTH*4
    @(negedge clk);
    bus0.MemWrite = 1'b1; bus0.Address = 32'h0; bus0.WriteData = 32'hA0A0A0A0; bus0.Size = 2'b00;
    #1;
    chk("w0.st1.stall", 32'(bus0.Stall), 32'd1);
    chk("w0.st1.ready_T", 32'(bus0.Ready), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("w0.st1.ready", 32'(bus0.Ready), 32'd1);
    chk("w0.st1.stall_resp", 32'(bus0.Stall), 32'd0);
    @(negedge clk);
    bus0.MemWrite = 1'b1; bus0.Address = 32'h1004; bus0.WriteData = 32'hB1B1B1B1;
    #1;
    chk("w0.st2.ready_T", 32'(bus0.Ready), 32'd0);
    chk("w0.st2.stall", 32'(bus0.Stall), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("w0.st2.ready", 32'(bus0.Ready), 32'd1);
    @(negedge clk);
    bus0.MemRead = 1'b1; bus0.Address = 32'h1000;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("w0.ld1000.ready", 32'(bus0.Ready), 32'd1);
    chk("w0.ld1000.rdata", bus0.ReadData, 32'hA0A0A0A0);
    @(negedge clk);
    bus0.MemRead = 1'b1; bus0.Address = 32'h4;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("w0.ld4.ready", 32'(bus0.Ready), 32'd1);
    chk("w0.ld4.rdata", bus0.ReadData, 32'hB1B1B1B1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
